key_debounce: RTL and testbench
===============================

# key_debounce

Debounces and conditions the board's active-low push-buttons before they reach the `keys_export` PIO of `nios_system`. Each key runs its own synchronizer, debounce counter and state machine. The block drives three outputs:
- a clean active-high level, wired to the keys PIO;
- one-cycle press pulses, for edge-capture logic and LED test hooks;
- one-cycle release pulses.

It sits between the top-level key pins and the Nios system, in the `clk_clk` domain.

## Interface
Parameters:
- `NUM_KEYS`, default 3: number of independent keys; matches the keys PIO width.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-input cycles required before a level change is accepted (20 ms at 50 MHz). Legal values are ≥ 2.
- `REPEAT_DELAY_CYCLES`, default 25_000_000: held time before the first auto-repeat pulse. Only used when auto-repeat is compiled in.
- `REPEAT_RATE_CYCLES`, default 5_000_000: interval between subsequent auto-repeat pulses. Only used when auto-repeat is compiled in.

Ports:
- `clk_clk` input 1: system clock, the same 50 MHz clock as `nios_system`.
- `reset_reset` input 1: synchronous, active-high reset.
- `keys_n` input NUM_KEYS: raw key pins; active low and asynchronous.
- `keys_level` output NUM_KEYS: debounced level, 1 = pressed; drives `keys_export`.
- `press_pulse` output NUM_KEYS: one-cycle strobe per accepted press, plus auto-repeat strobes when enabled.
- `release_pulse` output NUM_KEYS: one-cycle strobe per accepted release.

## Operation
- **Synchronizer:** a two-flop synchronizer runs per key. `raw[i] = ~sync2[i]`.
- **Counter:** `cnt[i]` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and saturates; it never wraps.
- **Per-key state machine:**
  - IDLE: when `raw=1`, load `cnt=1` and go to BOUNCE_DN.
  - BOUNCE_DN: if `raw=0`, clear `cnt` and return to IDLE. If `cnt==DEBOUNCE_CYCLES-1` and `raw=1`, go to HELD, set `keys_level=1` and pulse `press_pulse`. Otherwise increment `cnt`.
  - HELD: when `raw=0`, load `cnt=1` and go to BOUNCE_UP.
  - BOUNCE_UP: if `raw=1`, clear `cnt` and return to HELD. If `cnt==DEBOUNCE_CYCLES-1` and `raw=0`, go to IDLE, set `keys_level=0` and pulse `release_pulse`. Otherwise increment `cnt`.
- **Key independence:** keys are fully independent. Simultaneous events on several keys produce their pulses in the same cycle.
- **Bounces:** any bounce during BOUNCE_* restarts the debounce interval from zero. A bounce never produces a pulse.
- **Pulse exclusivity:** `press_pulse[i]` and `release_pulse[i]` are never high in the same cycle.
- **Reset:** sets sync flops to 1 (released), every state to IDLE, `cnt` to 0, and every output to 0.
- **Reset mid-operation:** all of the above is discarded. A key still held when reset is released must complete a full debounce interval before `keys_level` rises. Reset itself never produces `release_pulse`.

## Timing
- **Press latency:** if `keys_n[i]` goes low before edge N and stays low, `keys_level[i]` and `press_pulse[i]` assert at edge N+1+DEBOUNCE_CYCLES. This is 2 synchronizer cycles plus DEBOUNCE_CYCLES−1 counting cycles.
- **Release latency:** symmetric to press latency.
- **Pulse width:** every pulse is high for exactly 1 cycle.
- **Output registers:** all outputs are registered, with no combinational path from `keys_n`.
- **Minimum interval:** two accepted edges on one key are at least DEBOUNCE_CYCLES cycles apart.

## Configuration
- Macro: `KEY_DEBOUNCE_AUTOREPEAT_EN`.
- **Defined:** each key has a repeat counter that is cleared on entry to HELD.
  - Once the key has been in HELD for REPEAT_DELAY_CYCLES cycles, `press_pulse[i]` fires again.
  - After that, it fires every REPEAT_RATE_CYCLES cycles while the key stays in HELD.
  - In BOUNCE_UP the repeat counter freezes. If the key returns to HELD, counting resumes; if it goes to IDLE, the counter clears.
  - `keys_level` is unaffected.
- **Undefined:** there is no repeat counter. `press_pulse` fires exactly once per accepted press.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=5.
- **Reset values:** assert `reset_reset` for 3 cycles with `keys_n=3'b000`. During reset all outputs = 0. `keys_level` stays 0 until 10 cycles after deassertion, then reads `3'b111` with `press_pulse=3'b111` for 1 cycle.
- **Clean press/release:** `keys_n[0]` goes low at edge 0 and stays low. `keys_level[0]` rises at edge 9 with a 1-cycle `press_pulse[0]`. Release at edge 30 gives `keys_level[0]=0` and `release_pulse[0]` at edge 39.
- **Bounce:** toggle `keys_n[1]` low/high every 3 cycles for 30 cycles, then hold it low. There are no pulses during the toggling. `press_pulse[1]` fires exactly 9 cycles after the final falling edge.
- **Simultaneous keys:** `keys_n` goes from `3'b111` to `3'b010` at edge 0. `press_pulse=3'b101` at edge 9 and `keys_level=3'b101`.
- **Reset mid-bounce:** start pressing key 2, then assert reset at cycle 5 of BOUNCE_DN. After deassertion, `press_pulse[2]` fires a full 9 cycles later, not earlier.
- **Auto-repeat (`KEY_DEBOUNCE_AUTOREPEAT_EN` defined):**
  - Hold key 0 for 60 cycles after the press pulse. Repeat pulses occur at +20, +25, +30 … +60 after it.
  - With the macro undefined, only the initial pulse occurs.

Source files
------------

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer, saturating debounce counter and four-state FSM
// producing a clean level plus press/release strobes. Optional auto-repeat: KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce #(
  parameter int NUM_KEYS            = 3,
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] keys_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, BOUNCE_DN, HELD, BOUNCE_UP} state_t;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_params
    $error("key_debounce: illegal cycle parameters");
  end

  logic [NUM_KEYS-1:0] sync1, sync2;

  // Sync flops reset to 1 so a key held through reset still looks released afterwards.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving a true two-stage chain.
      sync1 <= keys_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          raw;
    logic          level_q, level_nxt;
    logic          press_q, press_nxt;
    logic          release_q, release_nxt;
    logic          rpt_fire;

    assign raw = ~sync2[i];

    always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = level_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (raw) begin
            cnt_nxt   = CW'(1);
            state_nxt = BOUNCE_DN;
          end
        end
        BOUNCE_DN: begin
          if (!raw) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = HELD;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HELD: begin
          if (!raw) begin
            cnt_nxt   = CW'(1);
            state_nxt = BOUNCE_UP;
          end
        end
        BOUNCE_UP: begin
          if (raw) begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end else if (cnt == CNT_LAST) begin
            cnt_nxt     = '0;
            state_nxt   = IDLE;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                                      : REPEAT_RATE_CYCLES;
    localparam int RW = $clog2(RMAX + 1);
    logic [RW-1:0] rpt, rpt_nxt;
    logic          rpt_armed, rpt_armed_nxt;

    // rpt_armed marks that the first (delay) pulse is done and the rate interval applies.
    always_comb begin
      rpt_nxt       = rpt;
      rpt_armed_nxt = rpt_armed;
      rpt_fire      = 1'b0;
      if (state_nxt == IDLE || (state == BOUNCE_DN && state_nxt == HELD)) begin
        rpt_nxt       = '0;
        rpt_armed_nxt = 1'b0;
      end else if (state == HELD) begin
        if (rpt == (rpt_armed ? RW'(REPEAT_RATE_CYCLES - 1) : RW'(REPEAT_DELAY_CYCLES - 1))) begin
          rpt_fire      = 1'b1;
          rpt_nxt       = '0;
          rpt_armed_nxt = 1'b1;
        end else begin
          rpt_nxt = rpt + RW'(1);
        end
      end
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        rpt       <= '0;
        rpt_armed <= 1'b0;
      end else begin
        rpt       <= rpt_nxt;
        rpt_armed <= rpt_armed_nxt;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt | rpt_fire;
        release_q <= release_nxt;
      end
    end

    assign keys_level[i]    = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat intervals.
// Build with KEY_DEBOUNCE_AUTOREPEAT_EN defined to also check auto-repeat pulses.
module tb_key_debounce;

  localparam int NK = 3;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RR = 5;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic [NK-1:0] keys_n;
  logic [NK-1:0] keys_level, press_pulse, release_pulse;

  int checks = 0;
  int errors = 0;
  logic [NK-1:0] exp_level;

  key_debounce #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .keys_n(keys_n),
    .keys_level(keys_level), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Inputs were changed just after the previous edge; the pulse lands D+2 steps later.
  task automatic pulse_seq(input string tag, input logic [NK-1:0] mask, input bit is_press);
    logic [NK-1:0] pre;
    pre = exp_level;
    for (int s = 1; s <= D + 1; s++) begin
      step();
      check({tag, "_early_press"}, press_pulse, '0);
      check({tag, "_early_release"}, release_pulse, '0);
      check({tag, "_early_level"}, keys_level, pre);
    end
    exp_level = is_press ? (pre | mask) : (pre & ~mask);
    step();
    check({tag, "_press"}, press_pulse, is_press ? mask : '0);
    check({tag, "_release"}, release_pulse, is_press ? '0 : mask);
    check({tag, "_level"}, keys_level, exp_level);
  endtask

  // Steps after a pulse; rpt_mask keys expect auto-repeat strobes when enabled.
  task automatic hold(input string tag, input int n, input logic [NK-1:0] rpt_mask);
    for (int k = 1; k <= n; k++) begin
      step();
      check({tag, "_hold_press"}, press_pulse,
            (AR && k >= RD && ((k - RD) % RR) == 0) ? rpt_mask : '0);
      check({tag, "_hold_release"}, release_pulse, '0);
      check({tag, "_hold_level"}, keys_level, exp_level);
    end
  endtask

  initial begin
    exp_level   = '0;
    reset_reset = 1'b1;
    keys_n      = 3'b000;
    for (int s = 0; s < 3; s++) begin
      step();
      check("rst_level", keys_level, '0);
      check("rst_press", press_pulse, '0);
      check("rst_release", release_pulse, '0);
    end
    reset_reset = 1'b0;
    pulse_seq("rst_exit", 3'b111, 1'b1);
    hold("rst_exit", 1, '0);

    // Reset while keys are held: level drops with no release strobe.
    reset_reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      step();
      check("rst_held_level", keys_level, '0);
      check("rst_held_release", release_pulse, '0);
    end
    exp_level   = '0;
    keys_n      = 3'b111;
    reset_reset = 1'b0;
    hold("rst_after", 12, '0);

    keys_n = 3'b110;
    pulse_seq("clean_dn", 3'b001, 1'b1);
    hold("clean_dn", 1, '0);
    keys_n = 3'b111;
    pulse_seq("clean_up", 3'b001, 1'b0);
    hold("clean_up", 1, '0);

    for (int t = 0; t < 5; t++) begin
      keys_n = 3'b101;
      hold("bounce_lo", 3, '0);
      keys_n = 3'b111;
      hold("bounce_hi", 3, '0);
    end
    keys_n = 3'b101;
    pulse_seq("bounce_dn", 3'b010, 1'b1);
    hold("bounce_dn", 1, '0);
    keys_n = 3'b111;
    pulse_seq("bounce_up", 3'b010, 1'b0);
    hold("bounce_up", 1, '0);

    keys_n = 3'b010;
    pulse_seq("simul_dn", 3'b101, 1'b1);
    hold("simul_dn", 1, '0);
    keys_n = 3'b111;
    pulse_seq("simul_up", 3'b101, 1'b0);
    hold("simul_up", 1, '0);

    // Key 2 reaches count 5 in BOUNCE_DN, then reset discards the progress.
    keys_n = 3'b011;
    hold("midb_pre", 7, '0);
    reset_reset = 1'b1;
    hold("midb_rst", 2, '0);
    reset_reset = 1'b0;
    pulse_seq("midb_dn", 3'b100, 1'b1);
    hold("midb_dn", 1, '0);
    keys_n = 3'b111;
    pulse_seq("midb_up", 3'b100, 1'b0);
    hold("midb_up", 1, '0);

    keys_n = 3'b110;
    pulse_seq("rpt_dn", 3'b001, 1'b1);
    hold("rpt", 60, 3'b001);
    keys_n = 3'b111;
    pulse_seq("rpt_up", 3'b001, 1'b0);
    hold("rpt_up", 2, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
